// File: rtl/fp_pkg.sv
// Shared definitions for the floatsip floating-point blocks. It holds the format
// widths, the special-value encodings and the operand classification.
package fp_pkg;

    typedef enum logic [1:0] {
        clsZero,
        clsNormal,
        clsInf,
        clsNan
    } fpClass_t;

    localparam logic [63:0] cAllOnes = '1;

    function automatic int expWidthOf(input int precision);
        case (precision)
            0:       return 5;
            1:       return 8;
            default: return 11;
        endcase
    endfunction

    function automatic int manWidthOf(input int precision);
        case (precision)
            0:       return 10;
            1:       return 23;
            default: return 52;
        endcase
    endfunction

    function automatic int biasOf(input int widthExp);
        return (1 << (widthExp - 1)) - 1;
    endfunction

    // Stored-mantissa field of the quiet NaN: a leading one with the rest zero.
    function automatic logic [63:0] qnanMan(input int widthMan);
        return 64'd1 << (widthMan - 1);
    endfunction

    // Subnormals carry exp=0 and are deliberately classified as zero (flushed).
    function automatic fpClass_t classify(input logic expZero, input logic expOnes,
                                          input logic manZero);
        if (expZero)  return clsZero;
        if (!expOnes) return clsNormal;
        if (manZero)  return clsInf;
        return clsNan;
    endfunction

    function automatic fpClass_t productClass(input fpClass_t a, input fpClass_t b);
        if (a == clsNan || b == clsNan) return clsNan;
        if ((a == clsZero && b == clsInf) || (a == clsInf && b == clsZero)) return clsNan;
        if (a == clsInf || b == clsInf) return clsInf;
        if (a == clsZero || b == clsZero) return clsZero;
        return clsNormal;
    endfunction

endpackage

// File: rtl/fp_mult_mant_mul.sv
// Pipelined unsigned significand multiplier. The product appears pLatency
// enabled cycles after the operands, and pLatency must be at least 1.
module fp_mult_mant_mul #(
    parameter string pTechnology = "ALTERA",
    parameter int    pWidth      = 11,
    parameter int    pLatency    = 4
)(
    input  logic                  i_Clk,
    input  logic                  i_ARst,
    input  logic                  i_ClkEn,
    input  logic [pWidth-1:0]     iv_A,
    input  logic [pWidth-1:0]     iv_B,
    output logic [2*pWidth-1:0]   ov_Product
);

    generate
        if (pTechnology == "ALTERA") begin : gAltera
            // Operands are registered first so the DSP block absorbs its input registers.
            logic [pWidth-1:0] aReg, bReg;

            always_ff @(posedge i_Clk) begin
                if (i_ARst) begin
                    aReg <= '0;
                    bReg <= '0;
                end else if (i_ClkEn) begin
                    aReg <= iv_A;
                    bReg <= iv_B;
                end
            end

            if (pLatency == 1) begin : gComb
                assign ov_Product = (2*pWidth)'(aReg) * (2*pWidth)'(bReg);
            end else begin : gOutRegs
                logic [2*pWidth-1:0] prodReg [pLatency-1];

                always_ff @(posedge i_Clk) begin
                    if (i_ARst) begin
                        for (int i = 0; i < pLatency - 1; i++) prodReg[i] <= '0;
                    end else if (i_ClkEn) begin
                        prodReg[0] <= (2*pWidth)'(aReg) * (2*pWidth)'(bReg);
                        for (int i = 1; i < pLatency - 1; i++) prodReg[i] <= prodReg[i-1];
                    end
                end

                assign ov_Product = prodReg[pLatency-2];
            end
        end else begin : gGeneric
            // The product feeds a register chain that synthesis retiming can spread out.
            logic [2*pWidth-1:0] prodReg [pLatency];

            always_ff @(posedge i_Clk) begin
                if (i_ARst) begin
                    for (int i = 0; i < pLatency; i++) prodReg[i] <= '0;
                end else if (i_ClkEn) begin
                    prodReg[0] <= (2*pWidth)'(iv_A) * (2*pWidth)'(iv_B);
                    for (int i = 1; i < pLatency; i++) prodReg[i] <= prodReg[i-1];
                end
            end

            assign ov_Product = prodReg[pLatency-1];
        end
    endgenerate

endmodule

// File: rtl/fp_mult.sv
// Pipelined IEEE-754 multiplier (half/single/double). The result appears with its
// transaction ID and exception flags exactly pPipeline enabled cycles after input.
module fp_mult
    import fp_pkg::*;
#(
    parameter string pTechnology = "ALTERA",
    parameter int    pPrecision  = 0,
    parameter int    pWidthExp   = expWidthOf(pPrecision),
    parameter int    pWidthMan   = manWidthOf(pPrecision),
    parameter int    pPipeline   = 5                          // legal range 2..8
)(
    input  logic                           i_Clk,
    input  logic                           i_ARst,
    input  logic                           i_ClkEn,
    input  logic                           i_Dv,
    input  logic [pWidthExp+pWidthMan:0]   iv_InputA,
    input  logic [pWidthExp+pWidthMan:0]   iv_InputB,
    output logic [2:0]                     o3_InputID,
    output logic [pWidthExp+pWidthMan:0]   ov_Result,
    output logic [2:0]                     o3_OuputID,
    output logic                           o_Overflow,
    output logic                           o_Underflow,
    output logic                           o_NAN,
    output logic                           o_PINF,
    output logic                           o_NINF
);

    localparam int cW     = pWidthExp + pWidthMan + 1;
    localparam int cSig   = pWidthMan + 1;
    localparam int cExpW  = pWidthExp + 2;
    localparam int cDelay = pPipeline - 1;
    localparam logic [cExpW-1:0]        cBias     = cExpW'(biasOf(pWidthExp));
    localparam logic signed [cExpW-1:0] cExpMax   = cExpW'((1 << pWidthExp) - 1);
    localparam logic signed [cExpW-1:0] cExpZero  = '0;
    localparam logic [pWidthExp-1:0]    cExpOnes  = cAllOnes[pWidthExp-1:0];
    localparam logic [63:0]             cQnanFull = qnanMan(pWidthMan);
    localparam logic [pWidthMan-1:0]    cQnanMan  = cQnanFull[pWidthMan-1:0];

    typedef struct packed {
        logic [2:0]       id;
        logic             sign;
        fpClass_t         cls;
        logic [cExpW-1:0] expSum;
    } sideBand_t;

    logic [2:0]           idCnt;
    logic [pWidthExp-1:0] expA, expB;
    logic [pWidthMan-1:0] manA, manB;
    fpClass_t             clsA, clsB;
    sideBand_t            sideIn, sideOut;
    sideBand_t            sidePipe [cDelay];
    logic [2*cSig-1:0]    prod;

    // NOTE: sequential state is written with non-blocking assignments (<=), so every
    // flop samples the values from before the edge no matter how the blocks are ordered.
    always_ff @(posedge i_Clk) begin
        if (i_ARst)                 idCnt <= 3'd1;
        else if (i_ClkEn && i_Dv)   idCnt <= (idCnt == 3'd7) ? 3'd1 : idCnt + 3'd1;
    end

    assign o3_InputID = i_Dv ? idCnt : 3'd0;

    assign expA = iv_InputA[cW-2 -: pWidthExp];
    assign expB = iv_InputB[cW-2 -: pWidthExp];
    assign manA = iv_InputA[pWidthMan-1:0];
    assign manB = iv_InputB[pWidthMan-1:0];
    assign clsA = classify(expA == '0, expA == cExpOnes, manA == '0);
    assign clsB = classify(expB == '0, expB == cExpOnes, manB == '0);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sideIn        = '0;
        sideIn.id     = o3_InputID;
        sideIn.sign   = iv_InputA[cW-1] ^ iv_InputB[cW-1];
        sideIn.cls    = productClass(clsA, clsB);
        sideIn.expSum = {2'b00, expA} + {2'b00, expB} - cBias;
    end

    // NOTE: this small delay line is a register pipeline and not a RAM. Resetting it
    // is what makes in-flight results vanish on reset.
    always_ff @(posedge i_Clk) begin
        if (i_ARst) begin
            for (int i = 0; i < cDelay; i++) sidePipe[i] <= '0;
        end else if (i_ClkEn) begin
            sidePipe[0] <= sideIn;
            for (int i = 1; i < cDelay; i++) sidePipe[i] <= sidePipe[i-1];
        end
    end

    assign sideOut = sidePipe[cDelay-1];

    fp_mult_mant_mul #(
        .pTechnology (pTechnology),
        .pWidth      (cSig),
        .pLatency    (cDelay)
    ) u_mantMul (
        .i_Clk      (i_Clk),
        .i_ARst     (i_ARst),
        .i_ClkEn    (i_ClkEn),
        .iv_A       ({1'b1, manA}),
        .iv_B       ({1'b1, manB}),
        .ov_Product (prod)
    );

    logic                    prodMsb, guardBit, stickyBit, roundUp;
    logic [pWidthMan-1:0]    manTrunc;
    logic [pWidthMan:0]      manRound;
    logic signed [cExpW-1:0] expFinal;
    logic [cW-1:0]           resultNext;
    logic                    ovfNext, udfNext, nanNext;

    always_comb begin
        prodMsb    = prod[2*cSig-1];
        manTrunc   = prodMsb ? prod[2*pWidthMan -: pWidthMan] : prod[2*pWidthMan-1 -: pWidthMan];
        guardBit   = prodMsb ? prod[pWidthMan] : prod[pWidthMan-1];
        stickyBit  = prodMsb ? |prod[pWidthMan-1:0] : |prod[pWidthMan-2:0];
        roundUp    = guardBit & (stickyBit | manTrunc[0]);
        manRound   = {1'b0, manTrunc} + {{pWidthMan{1'b0}}, roundUp};
        expFinal   = $signed(sideOut.expSum + {{(cExpW-1){1'b0}}, prodMsb}
                                            + {{(cExpW-1){1'b0}}, manRound[pWidthMan]});
        resultNext = '0;
        ovfNext    = 1'b0;
        udfNext    = 1'b0;
        nanNext    = 1'b0;
        if (sideOut.id != 3'd0) begin
            case (sideOut.cls)
                clsNan: begin
                    resultNext = {sideOut.sign, cExpOnes, cQnanMan};
                    nanNext    = 1'b1;
                end
                clsInf: begin
                    resultNext = {sideOut.sign, cExpOnes, {pWidthMan{1'b0}}};
                    ovfNext    = 1'b1;
                end
                clsZero: resultNext = {sideOut.sign, {(cW-1){1'b0}}};
                default: begin
                    // A rounding carry leaves manRound's low bits at zero, as required.
                    if (expFinal <= cExpZero) begin
                        resultNext = {sideOut.sign, {(cW-1){1'b0}}};
                        udfNext    = 1'b1;
                    end else if (expFinal >= cExpMax) begin
                        resultNext = {sideOut.sign, cExpOnes, {pWidthMan{1'b0}}};
                        ovfNext    = 1'b1;
                    end else begin
                        resultNext = {sideOut.sign, expFinal[pWidthExp-1:0], manRound[pWidthMan-1:0]};
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_ARst) begin
            ov_Result   <= '0;
            o3_OuputID  <= '0;
            o_Overflow  <= 1'b0;
            o_Underflow <= 1'b0;
            o_NAN       <= 1'b0;
            o_PINF      <= 1'b0;
            o_NINF      <= 1'b0;
        end else if (i_ClkEn) begin
            ov_Result   <= resultNext;
            o3_OuputID  <= sideOut.id;
            o_Overflow  <= ovfNext;
            o_Underflow <= udfNext;
            o_NAN       <= nanNext;
            o_PINF      <= ovfNext & ~sideOut.sign;
            o_NINF      <= ovfNext & sideOut.sign;
        end
    end

endmodule

// File: tb/tb_fp_mult.sv
// Bench for the half-precision fp_mult with pPipeline=5. Directed corner vectors and
// random traffic with stalls and bubbles are checked against an arithmetic reference.
module tb_fp_mult;

    localparam int cPipe = 5;

    logic        r_Clk = 1'b0;
    logic        r_ARst, r_ClkEn, r_Dv;
    logic [15:0] r_A, r_B;
    logic [2:0]  w_InputID, w_OutputID;
    logic [15:0] w_Result;
    logic        w_Ovf, w_Udf, w_Nan, w_Pinf, w_Ninf;

    always #5 r_Clk = ~r_Clk;

    fp_mult #(
        .pTechnology ("ALTERA"),
        .pPrecision  (0),
        .pWidthExp   (5),
        .pWidthMan   (10),
        .pPipeline   (cPipe)
    ) dut (
        .i_Clk       (r_Clk),
        .i_ARst      (r_ARst),
        .i_ClkEn     (r_ClkEn),
        .i_Dv        (r_Dv),
        .iv_InputA   (r_A),
        .iv_InputB   (r_B),
        .o3_InputID  (w_InputID),
        .ov_Result   (w_Result),
        .o3_OuputID  (w_OutputID),
        .o_Overflow  (w_Ovf),
        .o_Underflow (w_Udf),
        .o_NAN       (w_Nan),
        .o_PINF      (w_Pinf),
        .o_NINF      (w_Ninf)
    );

    int          total = 0;
    int          bad   = 0;
    int          nextId;
    logic [23:0] pipe [cPipe];   // expected {id, result, ovf, udf, nan, pinf, ninf}

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference: integer significand product, rounded by quotient/remainder, ties to even.
    function automatic logic [20:0] refMul(input logic [15:0] x, input logic [15:0] y);
        int     ex, ey, e, sh;
        longint mx, my, p, q, r, half;
        logic   s, nanX, nanY, infX, infY, zeroX, zeroY;
        s     = x[15] ^ y[15];
        ex    = int'(x[14:10]);
        ey    = int'(y[14:10]);
        mx    = longint'(x[9:0]);
        my    = longint'(y[9:0]);
        nanX  = (ex == 31) && (mx != 0);
        nanY  = (ey == 31) && (my != 0);
        infX  = (ex == 31) && (mx == 0);
        infY  = (ey == 31) && (my == 0);
        zeroX = (ex == 0);
        zeroY = (ey == 0);
        if (nanX || nanY || (zeroX && infY) || (infX && zeroY))
            return {s, 5'h1f, 10'h200, 5'b00100};
        if (infX || infY)
            return {s, 5'h1f, 10'h000, 3'b100, ~s, s};
        if (zeroX || zeroY)
            return {s, 15'h0000, 5'b00000};
        p    = (1024 + mx) * (1024 + my);
        sh   = (p >= 2097152) ? 11 : 10;
        q    = p >> sh;
        r    = p - (q << sh);
        half = longint'(1) << (sh - 1);
        if (r > half || (r == half && (q % 2) == 1)) q++;
        e = ex + ey - 15 + (sh - 10);
        if (q == 2048) begin
            q = 1024;
            e++;
        end
        if (e <= 0)  return {s, 15'h0000, 5'b01000};
        if (e >= 31) return {s, 5'h1f, 10'h000, 3'b100, ~s, s};
        return {s, e[4:0], q[9:0], 5'b00000};
    endfunction

    function automatic logic [15:0] randOp();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 11))
            0:       v[14:10] = 5'd0;
            1:       v[14:10] = 5'h1f;
            2:       v[14:0]  = 15'h7c00;
            3:       v[14:0]  = 15'h0000;
            4:       v[14:10] = 5'($urandom_range(25, 30));
            5:       v[14:10] = 5'($urandom_range(1, 6));
            default: v[14:10] = 5'($urandom_range(1, 30));
        endcase
        return v;
    endfunction

    task automatic step(input logic en, input logic dv, input logic [15:0] a,
                        input logic [15:0] b, input logic [20:0] want);
        @(negedge r_Clk);
        r_ARst  = 1'b0;
        r_ClkEn = en;
        r_Dv    = dv;
        r_A     = a;
        r_B     = b;
        #1 check("in_id", 32'(w_InputID), dv ? nextId : 0);
        @(posedge r_Clk);
        if (en) begin
            for (int i = cPipe - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = dv ? {nextId[2:0], want} : 24'h0;
            if (dv) nextId = (nextId == 7) ? 1 : nextId + 1;
        end
        #1 check("out", {w_OutputID, w_Result, w_Ovf, w_Udf, w_Nan, w_Pinf, w_Ninf},
                 32'(pipe[cPipe-1]));
    endtask

    task automatic applyReset();
        @(negedge r_Clk);
        r_ARst  = 1'b1;
        r_ClkEn = 1'b1;
        r_Dv    = 1'b1;
        r_A     = 16'h3c00;
        r_B     = 16'h3c00;
        @(posedge r_Clk);
        for (int i = 0; i < cPipe; i++) pipe[i] = 24'h0;
        nextId = 1;
        #1 check("reset_out", {w_OutputID, w_Result, w_Ovf, w_Udf, w_Nan, w_Pinf, w_Ninf}, 0);
    endtask

    // {A, B, expected result, expected {ovf, udf, nan, pinf, ninf}}
    localparam logic [52:0] cVecs [10] = '{
        {16'h3e00, 16'h3e00, 16'h4080, 5'b00000},
        {16'hbc00, 16'h4000, 16'hc000, 5'b00000},
        {16'h3c01, 16'h3e00, 16'h3e02, 5'b00000},
        {16'h3c01, 16'h3c01, 16'h3c02, 5'b00000},
        {16'h7bff, 16'h4000, 16'h7c00, 5'b10010},
        {16'hfc00, 16'h3c00, 16'hfc00, 5'b10001},
        {16'h0400, 16'h3800, 16'h0000, 5'b01000},
        {16'h0001, 16'h3c00, 16'h0000, 5'b00000},
        {16'h7e00, 16'h3c00, 16'h7e00, 5'b00100},
        {16'h7c00, 16'h0000, 16'h7e00, 5'b00100}
    };

    initial begin
        logic [52:0] vec;
        logic [15:0] ra, rb;
        logic        en, dv;
        r_ARst  = 1'b1;
        r_ClkEn = 1'b1;
        r_Dv    = 1'b0;
        r_A     = '0;
        r_B     = '0;
        nextId  = 1;
        for (int i = 0; i < cPipe; i++) pipe[i] = 24'h0;

        applyReset();

        // Back-to-back directed vectors: IDs run 1..7 then wrap to 1.
        for (int i = 0; i < 10; i++) begin
            vec = cVecs[i];
            step(1'b1, 1'b1, vec[52:37], vec[36:21], vec[20:0]);
        end
        step(1'b1, 1'b0, 16'h0, 16'h0, 21'h0);
        step(1'b1, 1'b0, 16'h0, 16'h0, 21'h0);
        for (int i = 0; i < 3; i++) begin
            ra = randOp();
            rb = randOp();
            step(1'b0, 1'b1, ra, rb, refMul(ra, rb));
        end

        for (int n = 0; n < 400; n++) begin
            if (n == 40) begin
                for (int k = 0; k < 3; k++) begin
                    ra = randOp();
                    rb = randOp();
                    step(1'b0, 1'b1, ra, rb, refMul(ra, rb));
                end
            end
            en = ($urandom_range(0, 9) != 0);
            dv = ($urandom_range(0, 3) != 0);
            ra = randOp();
            rb = randOp();
            step(en, dv, ra, rb, refMul(ra, rb));
        end

        // Reset while results are still in flight, then make sure the pipeline restarts at ID 1.
        applyReset();
        step(1'b1, 1'b1, 16'h3e00, 16'h3e00, {16'h4080, 5'b00000});
        for (int i = 0; i < cPipe; i++) step(1'b1, 1'b0, 16'h0, 16'h0, 21'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
